// File: rtl/usart_pkg.sv
// Shared types and constants for the USART rx/tx cores and the echo top level.
package usart_pkg;
    localparam int DIV_WIDTH = 12;
    localparam int DATA_BITS = 8;
    localparam int BITCNT_W  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } usart_state_t;

    // Dividers below 2 would leave no room for a half-bit wait, so clamp them.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
        return (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
    endfunction
endpackage

// File: rtl/usart_rx.sv
// 8N1 receiver: 2-flop input synchronizer, centre sampling, 1-cycle valid per good byte.
module usart_rx
    import usart_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid
);
    logic                 r_sync1;
    logic                 r_sync2;
    usart_state_t         r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [BITCNT_W-1:0]  r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 w_expire;

    assign w_expire = (r_cnt == DIV_WIDTH'(1));

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            o_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_div   <= eff_div(i_div);
                        r_cnt   <= eff_div(i_div) >> 1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_expire) begin
                        if (r_sync2) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_cnt   <= r_div;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (w_expire) begin
                        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= r_div;
                        r_bit   <= r_bit + BITCNT_W'(1);
                        if (r_bit == BITCNT_W'(DATA_BITS - 1))
                            r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    // After a framing error, park here until the line returns high.
                    if (r_ferr) begin
                        if (r_sync2) begin
                            r_ferr  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_expire) begin
                        if (r_sync2) begin
                            o_valid <= 1'b1;
                            o_data  <= r_shift;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/usart_tx.sv
// 8N1 transmitter; o_busy low means a valid byte is accepted on this clock edge.
module usart_tx
    import usart_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_busy,
    output logic                 o_tx
);
    usart_state_t         r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [BITCNT_W-1:0]  r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 w_expire;

    assign w_expire = (r_cnt == DIV_WIDTH'(1));
    // Accepting at the last stop-bit cycle gives back-to-back frames.
    assign o_busy   = !((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_expire));
    assign o_tx     = r_tx;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_div   <= eff_div(i_div);
                        r_cnt   <= eff_div(i_div);
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_expire) begin
                        r_cnt   <= r_div;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (w_expire) begin
                        r_cnt <= r_div;
                        if (r_bit == BITCNT_W'(DATA_BITS - 1)) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + BITCNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (w_expire) begin
                        if (i_valid) begin
                            r_div   <= eff_div(i_div);
                            r_cnt   <= eff_div(i_div);
                            r_shift <= i_data;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/usart_echo.sv
// Serial loopback: received bytes are queued in a small FIFO and retransmitted.
module usart_echo
    import usart_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                 comm_clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] clock_divider,
    input  logic                 rx_pin,
    output logic                 tx_pin
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_BITS-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [DATA_BITS-1:0] w_rx_data;
    logic                 w_rx_valid;
    logic                 w_tx_busy;
    logic                 w_tx_valid;
    logic [DATA_BITS-1:0] w_tx_data;
    logic                 w_fifo_empty;
    logic                 w_take;
    logic                 w_pop;
    logic                 w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    usart_rx u_rx (
        .i_clk   (comm_clock),
        .i_srst  (reset),
        .i_div   (clock_divider),
        .i_rx    (rx_pin),
        .o_data  (w_rx_data),
        .o_valid (w_rx_valid)
    );

    // An empty FIFO is bypassed so a fresh byte reaches the transmitter one cycle sooner.
    assign w_fifo_empty = (r_count == '0);
    assign w_tx_valid   = !w_fifo_empty || w_rx_valid;
    assign w_tx_data    = w_fifo_empty ? w_rx_data : r_mem[r_rd_ptr];
    assign w_take       = w_tx_valid && !w_tx_busy;
    assign w_pop        = w_take && !w_fifo_empty;
    assign w_push       = w_rx_valid && !(w_take && w_fifo_empty)
                          && ((r_count != CNT_W'(BUF_DEPTH)) || w_pop);

    usart_tx u_tx (
        .i_clk   (comm_clock),
        .i_srst  (reset),
        .i_div   (clock_divider),
        .i_data  (w_tx_data),
        .i_valid (w_take),
        .o_busy  (w_tx_busy),
        .o_tx    (tx_pin)
    );

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rx_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_usart_echo.sv
// Randomised loopback bench: a line-level UART monitor decodes tx_pin and is checked against expected bytes and low-run widths.
module tb_usart_echo;
    import usart_pkg::*;

    logic                 comm_clock = 1'b0;
    logic                 reset = 1'b1;
    logic [DIV_WIDTH-1:0] clock_divider = DIV_WIDTH'(64);
    logic                 rx_pin = 1'b1;
    logic                 tx_pin;

    usart_echo dut (
        .comm_clock    (comm_clock),
        .reset         (reset),
        .clock_divider (clock_divider),
        .rx_pin        (rx_pin),
        .tx_pin        (tx_pin)
    );

    always #5 comm_clock = ~comm_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge comm_clock) cyc <= cyc + 1;

    // Reference-side state: what the line should show.
    int exp_byte[$];
    int exp_runs[$];
    // Observed state decoded from tx_pin.
    int got_byte[$];
    int got_ok[$];
    int got_start[$];
    int low_runs[$];
    int run_len = 0;
    bit mon_en  = 1'b0;
    int mon_div = 64;
    int stop_centre_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Expected tx line: start(0), data LSB first, stop(1); record each run of zeros in cycles.
    task automatic add_expected(input logic [7:0] b, input int d);
        logic [9:0] bits;
        int run;
        bits = {1'b1, b, 1'b0};
        run = 0;
        exp_byte.push_back(int'(b));
        for (int k = 0; k < 10; k++) begin
            if (bits[k] == 1'b0) run++;
            else if (run > 0) begin
                exp_runs.push_back(run * d);
                run = 0;
            end
        end
    endtask

    // Must be entered at a falling edge; leaves the line idle at a falling edge.
    task automatic send_frame(input logic [7:0] b, input int d, input bit stop_bit);
        rx_pin = 1'b0;
        repeat (d) @(negedge comm_clock);
        for (int k = 0; k < 8; k++) begin
            rx_pin = b[k];
            repeat (d) @(negedge comm_clock);
        end
        rx_pin = stop_bit;
        stop_centre_cyc = cyc + 1 + d / 2;
        repeat (d) @(negedge comm_clock);
        rx_pin = 1'b1;
    endtask

    task automatic finish_batch(input string tag, input int d, output int start_gap);
        int budget;
        int n;
        budget = (exp_byte.size() + 2) * 12 * d + 200;
        while (got_byte.size() < exp_byte.size() && budget > 0) begin
            @(negedge comm_clock);
            budget--;
        end
        repeat (12 * d + 20) @(negedge comm_clock);
        check({tag, " echo_count"}, got_byte.size(), exp_byte.size());
        n = (got_byte.size() < exp_byte.size()) ? got_byte.size() : exp_byte.size();
        for (int i = 0; i < n; i++) begin
            $display("[TB] %s byte %0d: got 0x%02h expected 0x%02h stop_ok=%0d", tag, i,
                     got_byte[i], exp_byte[i], got_ok[i]);
            check({tag, " byte"}, got_byte[i], exp_byte[i]);
            check({tag, " frame_ok"}, got_ok[i], 1);
        end
        check({tag, " low_run_count"}, low_runs.size(), exp_runs.size());
        n = (low_runs.size() < exp_runs.size()) ? low_runs.size() : exp_runs.size();
        for (int i = 0; i < n; i++)
            check({tag, " low_run_width"}, low_runs[i], exp_runs[i]);
        start_gap = (got_start.size() >= 2) ? (got_start[1] - got_start[0]) : -1;
        exp_byte.delete();
        exp_runs.delete();
        got_byte.delete();
        got_ok.delete();
        got_start.delete();
        low_runs.delete();
    endtask

    // Zero-run tracker on tx_pin.
    always @(negedge comm_clock) begin
        if (!mon_en) run_len = 0;
        else if (tx_pin == 1'b0) run_len++;
        else if (run_len > 0) begin
            low_runs.push_back(run_len);
            run_len = 0;
        end
    end

    // UART monitor: samples tx_pin at bit centres after each falling start edge.
    initial begin : monitor
        int st;
        int d;
        int b;
        bit ok;
        bit live;
        forever begin
            @(negedge comm_clock);
            if (mon_en && tx_pin == 1'b0) begin
                st = cyc;
                d = mon_div;
                b = 0;
                live = 1'b1;
                repeat (d / 2) @(negedge comm_clock);
                ok = (tx_pin == 1'b0);
                live &= mon_en;
                for (int k = 0; k < 8; k++) begin
                    repeat (d) @(negedge comm_clock);
                    b |= int'(tx_pin) << k;
                    live &= mon_en;
                end
                repeat (d) @(negedge comm_clock);
                ok &= (tx_pin == 1'b1);
                live &= mon_en;
                if (live) begin
                    got_byte.push_back(b);
                    got_ok.push_back(int'(ok));
                    got_start.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge comm_clock);
        $display("FAIL watchdog: reached cycle %0d, required finish before 95000", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        int lows;
        int gap;
        int centre;
        int diff;
        int raw;
        int d;
        logic [7:0] rb;

        // Reset and quiet line.
        repeat (5) @(negedge comm_clock);
        check("tx_high_in_reset", tx_pin, 1);
        reset = 1'b0;
        mon_en = 1'b1;
        mon_div = 64;
        lows = 0;
        repeat (1000) begin
            @(negedge comm_clock);
            if (tx_pin == 1'b0) lows++;
        end
        check("idle_tx_low_cycles", lows, 0);
        check("idle_bytes", got_byte.size(), 0);

        // Single frame 0x75 at div 64, with start-bit latency.
        add_expected(8'h75, 64);
        send_frame(8'h75, 64, 1'b1);
        centre = stop_centre_cyc;
        finish_batch("single_75", 64, gap);
        // got_start was cleared; re-derive latency from a second identical frame.
        add_expected(8'h75, 64);
        send_frame(8'h75, 64, 1'b1);
        centre = stop_centre_cyc;
        repeat (40) @(negedge comm_clock);
        diff = (got_start.size() > 0) ? -1 : 0;
        repeat (700) @(negedge comm_clock);
        diff = (got_start.size() > 0) ? (got_start[0] - centre) : 1000;
        $display("[TB] latency rx stop centre -> tx start: %0d cycles", diff);
        check("latency_within_4", (diff >= 0 && diff <= 4) ? 1 : 0, 1);
        finish_batch("latency_75", 64, gap);

        // 0x75, 50 idle cycles, 0x8A.
        add_expected(8'h75, 64);
        add_expected(8'h8A, 64);
        send_frame(8'h75, 64, 1'b1);
        repeat (50) @(negedge comm_clock);
        send_frame(8'h8A, 64, 1'b1);
        finish_batch("pair_75_8a", 64, gap);

        // Zero-gap frames: the echo must be back-to-back.
        clock_divider = DIV_WIDTH'(16);
        mon_div = 16;
        add_expected(8'h0F, 16);
        add_expected(8'hF0, 16);
        send_frame(8'h0F, 16, 1'b1);
        send_frame(8'hF0, 16, 1'b1);
        finish_batch("back_to_back", 16, gap);
        check("back_to_back_start_spacing", gap, 160);

        // Glitch shorter than half a bit.
        clock_divider = DIV_WIDTH'(64);
        mon_div = 64;
        rx_pin = 1'b0;
        repeat (10) @(negedge comm_clock);
        rx_pin = 1'b1;
        finish_batch("glitch", 64, gap);

        // Framing error on 0x55, then a good 0x33.
        add_expected(8'h33, 64);
        send_frame(8'h55, 64, 1'b0);
        repeat (64) @(negedge comm_clock);
        send_frame(8'h33, 64, 1'b1);
        finish_batch("framing_err", 64, gap);

        // Reset during data bit 3 of echo of 0x35 (bit 3 is 0).
        send_frame(8'h35, 64, 1'b1);
        repeat (260) @(negedge comm_clock);
        check("pre_reset_tx_bit3", tx_pin, 0);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge comm_clock);
        check("tx_high_after_reset", tx_pin, 1);
        repeat (3) @(negedge comm_clock);
        reset = 1'b0;
        repeat (1300) @(negedge comm_clock);
        check("tx_idle_after_release", tx_pin, 1);
        got_byte.delete();
        got_ok.delete();
        got_start.delete();
        low_runs.delete();
        mon_en = 1'b1;
        add_expected(8'hA5, 64);
        send_frame(8'hA5, 64, 1'b1);
        finish_batch("after_reset_a5", 64, gap);

        // Randomised batches; the first uses a divider below 2.
        for (int batch = 0; batch < 4; batch++) begin
            raw = (batch == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(3, 48));
            d = (raw < 2) ? 2 : raw;
            clock_divider = DIV_WIDTH'(raw);
            mon_div = d;
            $display("[TB] random batch %0d: clock_divider=%0d effective=%0d", batch, raw, d);
            for (int i = 0; i < 5; i++) begin
                rb = 8'($urandom);
                add_expected(rb, d);
                send_frame(rb, d, 1'b1);
                repeat ($urandom_range(2 * d, 3 * d)) @(negedge comm_clock);
            end
            finish_batch("random", d, gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
